if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It is the producer side of the IF→ID interface: it drives fs_to_ds_valid/fs_to_ds_bus, consumes ds_allowin, and consumes br_bus from ID. It owns the fetch PC, issues one instruction request at a time on an SRAM-like request/response port, and implements the MIPS branch delay slot by holding branch redirects until the delay-slot instruction has been handed to ID.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
clk  in  1  clock.
reset  in  1  reset; synchronous, active-high.
ds_allowin  in  1  ID can accept an instruction this cycle.
br_bus  in  `BR_BUS_WD (33)  {br_taken[32], br_target[31:0]} from ID.
fs_to_ds_valid  out  1  instruction valid toward ID.
fs_to_ds_bus  out  `FS_TO_DS_BUS_WD (64)  {inst[63:32], fs_pc[31:0]}.
inst_sram_req  out  1  fetch request.
inst_sram_wr  out  1  tied 0.
inst_sram_size  out  2  tied 2'd2 (word).
inst_sram_addr  out  32  fetch address (= fs_pc).
inst_sram_wdata  out  32  tied 0.
inst_sram_addr_ok  in  1  request accepted this cycle.
inst_sram_data_ok  in  1  read data valid this cycle.
inst_sram_rdata  in  32  instruction word.

Behaviour:
- State machine with three states:
  - REQ: inst_sram_req=1, addr=fs_pc. On addr_ok, go to WAIT. addr is held stable until accepted.
  - WAIT: req=0. On data_ok, inst_buf<=rdata and go to VALID.
  - VALID: fs_to_ds_valid=1. On handoff (fs_to_ds_valid && ds_allowin), fs_pc<=next_pc and go to REQ.
- At most one outstanding request. A data_ok seen in REQ or VALID is ignored; the SRAM is not allowed to produce one there.
- fs_pc is driven on fs_to_ds_bus[31:0] in every state. ID reads it combinationally as the delay-slot PC for target calculation.
- Reset: state=REQ, fs_pc=RESET_PC, fs_to_ds_valid=0, br_buf_valid=0, inst_buf=0. inst_sram_req=1 in the first cycle after reset. The SRAM shares reset, so no stale data_ok arrives. Reset in any state aborts that state immediately.
- br_bus contract: ID asserts br_taken only when its operands are final, i.e. gated by ID ready.
- Branch buffer (br_buf_valid, br_buf_target):
  - Every cycle br_taken=1 and no handoff occurs: br_buf_valid<=1 and br_buf_target<=br_target (latest value wins).
  - Cleared on every handoff.
- next_pc priority at handoff:
  1. br_taken ? br_target
  2. br_buf_valid ? br_buf_target
  3. fs_pc+4 (32-bit wrap).
  The handed-off instruction is always the delay slot of the pending branch, because the branch occupied ID while fs_pc held PC+4.
- Simultaneous br_taken and handoff: the live br_target is used and the buffer is not written.
- Latency: minimum 3 cycles per instruction (REQ → WAIT → VALID), assuming 1-cycle addr_ok and 1-cycle data_ok.
- No exceptions are raised: an unaligned target is issued as-is.

Decomposition:
- mycpu.h already holds FS_TO_DS_BUS_WD=64 and BR_BUS_WD=33. Add the IF state encodings there (FS_REQ=2'd0, FS_WAIT=2'd1, FS_VALID=2'd2).
- No sub-module; the branch buffer and next-PC mux stay inline.

Test Plan:
1. Reset release, addr_ok=1 immediately, data_ok next cycle with rdata 0x24010001 → req addr 0xBFC00000; fs_to_ds_valid=1 two cycles after acceptance; bus={0x24010001, 0xBFC00000}.
2. ds_allowin=1, zero-wait SRAM → fetched addresses 0xBFC00000, 0xBFC00004, 0xBFC00008, with one handoff every 3 cycles.
3. Branch at 0xBFC00004 in ID: br_taken=1, target 0xBFC00100, asserted in the same cycle as handoff of slot 0xBFC00008 → next request addr 0xBFC00100, then 0xBFC00104.
4. br_taken pulses 1 cycle (target 0xBFC00200) while IF is in WAIT for the slot, then deasserts → slot handed off, next request 0xBFC00200, br_buf_valid=0 afterwards, following request 0xBFC00204.
5. ds_allowin=0 for 5 cycles in VALID → fs_to_ds_valid held 1, bus unchanged, inst_sram_req=0 throughout; handoff on the 6th cycle.
6. addr_ok withheld 4 cycles in REQ → req and addr stable; then reset asserted in WAIT → next cycle state REQ, addr=0xBFC00000, fs_to_ds_valid=0, br_buf_valid=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, IF state
// encodings and the sequential-PC helper.
package if_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int BR_BUS_WD       = 33;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_VALID = 2'd2
    } fs_state_e;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: one outstanding SRAM request, an IF->ID
// valid/allowin handoff, and a branch buffer that defers redirects past the delay slot.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    fs_state_e   state;
    fs_state_e   state_next;
    logic [31:0] fs_pc;
    logic [31:0] inst_buf;
    logic        br_buf_valid;
    logic [31:0] br_buf_target;
    logic [31:0] next_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        handoff;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    assign fs_to_ds_valid = (state == FS_VALID);
    assign handoff        = fs_to_ds_valid && ds_allowin;
    assign fs_to_ds_bus   = {inst_buf, fs_pc};

    assign inst_sram_req   = (state == FS_REQ);
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_addr  = fs_pc;
    assign inst_sram_wdata = 32'h0;

    // A live redirect beats a buffered one; both only land on the delay slot's handoff.
    always_comb begin
        next_pc = seq_pc(fs_pc);
        if (br_taken) begin
            next_pc = br_target;
        end else if (br_buf_valid) begin
            next_pc = br_buf_target;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FS_REQ:   if (inst_sram_addr_ok) state_next = FS_WAIT;
            FS_WAIT:  if (inst_sram_data_ok) state_next = FS_VALID;
            FS_VALID: if (handoff)           state_next = FS_REQ;
            default:                         state_next = FS_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FS_REQ;
            fs_pc        <= RESET_PC;
            inst_buf     <= 32'h0;
            br_buf_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (state == FS_WAIT && inst_sram_data_ok) begin
                inst_buf <= inst_sram_rdata;
            end
            if (handoff) begin
                fs_pc        <= next_pc;
                br_buf_valid <= 1'b0;
            end else if (br_taken) begin
                br_buf_valid <= 1'b1;
            end
        end
    end

    // Target is data only; its validity flag above carries the reset.
    always_ff @(posedge clk) begin
        if (!handoff && br_taken) begin
            br_buf_target <= br_target;
        end
    end

endmodule
